// File: rtl/scan_decoder.sv
// Row drive decoder: direct one-hot decode of sel, or an autonomous row scan
// with a programmable per-row dwell and a one-cycle blank gap between rows.
module scan_decoder #(
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned DWELL_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [(2**SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        idx,
  output logic                    frame_start,
  output logic                    row_tick
);

  localparam int unsigned OUTS = 2**SEL_W;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DIRECT     = 2'd1,
    S_SCAN_ON    = 2'd2,
    S_SCAN_BLANK = 2'd3
  } state_t;

  state_t               r_state;
  logic [OUTS-1:0]      r_out;
  logic [SEL_W-1:0]     r_idx;
  logic                 r_frame_start;
  logic                 r_row_tick;
  logic [DWELL_W-1:0]   r_cnt;

  state_t               w_state;
  logic [OUTS-1:0]      w_out;
  logic [SEL_W-1:0]     w_idx;
  logic                 w_frame_start;
  logic                 w_row_tick;
  logic [DWELL_W-1:0]   w_cnt;
  logic [DWELL_W-1:0]   w_dwell_load;
  logic [SEL_W-1:0]     w_idx_inc;

  // A zero dwell still gives every row one active cycle.
  assign w_dwell_load = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign w_idx_inc    = r_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_out         <= '0;
      r_idx         <= '0;
      r_frame_start <= 1'b0;
      r_row_tick    <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state;
      r_out         <= w_out;
      r_idx         <= w_idx;
      r_frame_start <= w_frame_start;
      r_row_tick    <= w_row_tick;
      r_cnt         <= w_cnt;
    end
  end

  // Next state and next registered outputs; enable outranks mode, mode outranks scan progress.
  always_comb begin
    w_state       = r_state;
    w_out         = r_out;
    w_idx         = r_idx;
    w_frame_start = 1'b0;
    w_row_tick    = 1'b0;
    w_cnt         = r_cnt;

    if (!enable) begin
      w_state = S_IDLE;
      w_out   = '0;
      w_idx   = '0;
      w_cnt   = '0;
    end else if (!mode) begin
      w_state = S_DIRECT;
      w_out   = OUTS'(1) << sel;
      w_idx   = sel;
      w_cnt   = '0;
    end else begin
      case (r_state)
        S_SCAN_ON: begin
          if (r_cnt <= DWELL_W'(1)) begin
            w_state = S_SCAN_BLANK;
            w_out   = '0;
            w_cnt   = '0;
          end else begin
            w_cnt   = r_cnt - DWELL_W'(1);
          end
        end
        S_SCAN_BLANK: begin
          w_state       = S_SCAN_ON;
          w_idx         = w_idx_inc;
          w_out         = OUTS'(1) << w_idx_inc;
          w_cnt         = w_dwell_load;
          w_row_tick    = 1'b1;
          w_frame_start = (w_idx_inc == '0);
        end
        default: begin
          // Scan entry from IDLE or DIRECT always restarts at row 0.
          w_state       = S_SCAN_ON;
          w_idx         = '0;
          w_out         = OUTS'(1);
          w_cnt         = w_dwell_load;
          w_row_tick    = 1'b1;
          w_frame_start = 1'b1;
        end
      endcase
    end
  end

  assign out         = r_out;
  assign idx         = r_idx;
  assign frame_start = r_frame_start;
  assign row_tick    = r_row_tick;

  a_out_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(out));

endmodule
